// File: rtl/pipeline_stage_buf_pkg.sv
// pipeline_stage_buf_pkg: state encodings and default bundle widths for the inter-stage buffer
package pipeline_stage_buf_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 3 * XLEN + REG_ADDR_W;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;
endpackage

// File: rtl/pipeline_stage_buf.sv
// pipeline_stage_buf: elastic two-entry skid buffer between pipeline stages with flush and registered o_ready
module pipeline_stage_buf
    import pipeline_stage_buf_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit ZERO_CTRL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);
    logic [1:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              in_fire, out_fire, load_in, load_skid, to_skid;

    assign o_valid = state_q != ST_EMPTY;
    assign o_ready = ready_q;
    assign o_count = state_q;
    assign o_data  = main_data_q;
    assign o_ctrl  = (ZERO_CTRL && !o_valid) ? '0 : main_ctrl_q;

    // next state and register selects; flush wins over any handshake and drops the incoming entry
    always_comb begin
        in_fire     = i_valid & ready_q;
        out_fire    = o_valid & i_ready;
        load_in     = !i_flush && in_fire && (state_q == ST_EMPTY || out_fire);
        load_skid   = !i_flush && state_q == ST_SKID && out_fire;
        to_skid     = !i_flush && state_q == ST_FULL && in_fire && !out_fire;
        state_d     = i_flush ? ST_EMPTY :
                      state_q == ST_EMPTY ? (in_fire ? ST_FULL : ST_EMPTY) :
                      state_q == ST_FULL  ? (to_skid ? ST_SKID : (out_fire && !in_fire) ? ST_EMPTY : ST_FULL) :
                      state_q == ST_SKID  ? (out_fire ? ST_FULL : ST_SKID) : ST_EMPTY;
        ready_d     = state_d != ST_SKID;
        main_ctrl_d = load_in ? i_ctrl : load_skid ? skid_ctrl_q : main_ctrl_q;
        main_data_d = load_in ? i_data : load_skid ? skid_data_q : main_data_q;
        skid_ctrl_d = to_skid ? i_ctrl : skid_ctrl_q;
        skid_data_d = to_skid ? i_data : skid_data_q;
    end

    // state, ready and payload registers; reset clears everything and holds o_ready low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end
endmodule

// File: tb/tb_pipeline_stage_buf.sv
// tb_pipeline_stage_buf: directed and random stimulus against a queue model of the two-entry buffer
module tb_pipeline_stage_buf;
    typedef struct {
        logic [7:0]   c;
        logic [100:0] d;
    } ent_t;

    logic         clk, rst, flush, valid_i, ready_i;
    logic [7:0]   ctrl_i;
    logic [100:0] data_i;
    logic         ready_o, valid_o;
    logic [7:0]   ctrl_o;
    logic [100:0] data_o;
    logic [1:0]   count_o;

    ent_t         q[$];
    logic [100:0] md;
    bit           rdy_m, live;
    int           total, fails;

    pipeline_stage_buf #(.CTRL_W(8), .DATA_W(101), .ZERO_CTRL(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid_i), .o_ready(ready_o),
        .i_ctrl(ctrl_i), .i_data(data_i), .o_valid(valid_o), .i_ready(ready_i),
        .o_ctrl(ctrl_o), .o_data(data_o), .o_count(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] c, input logic [100:0] d,
                         input logic r, input logic fl, input logic rs);
        ent_t       e;
        bit         er, inf, outf;
        logic [7:0] ec;
        @(negedge clk);
        valid_i = v; ctrl_i = c; data_i = d; ready_i = r; flush = fl; rst = rs;
        #1;
        er = rdy_m && q.size() < 2;
        if (live) begin
            ec = 8'h0;
            if (q.size() != 0) ec = q[0].c;
            chk("o_valid", 128'(valid_o), 128'(q.size() != 0));
            chk("o_count", 128'(count_o), 128'(q.size()));
            chk("o_ready", 128'(ready_o), 128'(er));
            chk("o_data",  128'(data_o),  128'(md));
            chk("o_ctrl",  128'(ctrl_o),  128'(ec));
        end
        inf  = v && er;
        outf = q.size() != 0 && r;
        e.c = c; e.d = d;
        if (rs) begin
            q.delete(); rdy_m = 0; md = '0; live = 1;
        end else begin
            rdy_m = 1;
            if (fl) q.delete();
            else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(e);
            end
            if (q.size() != 0) md = q[0].d;
        end
        @(posedge clk);
    endtask

    initial begin
        total = 0; fails = 0; rdy_m = 0; live = 0; md = '0;
        rst = 1; flush = 0; valid_i = 0; ready_i = 0; ctrl_i = 0; data_i = 0;
        cycle(0, 8'h00, 101'd0, 0, 0, 1);
        cycle(0, 8'h00, 101'd0, 0, 0, 1);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(1, 8'hA5, 101'd1, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        for (int i = 1; i <= 20; i++) cycle(1, 8'(i), 101'(i), 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(1, 8'h11, 101'h111, 0, 0, 0);
        cycle(1, 8'h22, 101'h222, 0, 0, 0);
        cycle(1, 8'h33, 101'h333, 0, 0, 0);
        cycle(0, 8'h00, 101'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(1, 8'h44, 101'h444, 0, 0, 0);
        cycle(1, 8'h55, 101'h555, 0, 0, 0);
        cycle(1, 8'h66, 101'h666, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 101'd0, 1, 0, 0);
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom), {69'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0), 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(1, 8'h77, 101'h777, 0, 0, 0);
        cycle(0, 8'h00, 101'd0, 0, 0, 1);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(1, 8'h88, 101'h888, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        cycle(0, 8'h00, 101'd0, 1, 0, 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
